l2_port_arbiter: RTL and testbench
==================================

// Module: l2_port_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer between the two L1-side request ports and the shared L2 cache.
//  Captures one request at a time and drives a single L2 command (select, rd/wr, tag, index, wdata).
//  Holds the command until L2 acknowledges, then signals completion to the owning port.
//  Sits between the L1 controllers / coherence bus and the L2 cache. Also flags L2 stalls via timeout.
// PARAMETERS
//  tag_bits      24   tag width
//  index_bits    7    index width
//  block_size    512  write-data block width
//  timeout_cycs  15   max WAIT cycles before abort, 1..2^to_bits-1
//  to_bits       4    timeout counter width
// PORTS
//  CLK          in   1           clock, rising edge
//  RST          in   1           synchronous, active-low reset
//  req_1/req_2  in   1           port request; held high until done_x
//  wr_1/wr_2    in   1           1=write, 0=read; stable while req_x high
//  tag_1/tag_2  in   tag_bits    request tag
//  index_1/2    in   index_bits  request index
//  wdata_1/2    in   block_size  write data
//  gnt_1/gnt_2  out  1           1-cycle pulse: request captured
//  done_1/2     out  1           1-cycle pulse: request finished
//  timeout_err  out  1           1-cycle pulse with done_x when aborted
//  l2_valid     out  1           L2 command active
//  l2_sel       out  1           0=port 1 owns L2, 1=port 2
//  l2_rd/l2_wr  out  1           command type; one-hot when l2_valid
//  l2_tag       out  tag_bits    latched tag
//  l2_index     out  index_bits  latched index
//  l2_wdata     out  block_size  latched write data
//  l2_ack       in   1           L2 completion (read data valid or write done)
// BEHAVIOUR
//  - Reset (RST=0 at posedge): state=IDLE, prio=port 1, counter=0; all outputs 0, incl. l2_tag/index/wdata.
//  - FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  - IDLE: if any req_x, pick winner; go to ISSUE and latch that port's wr/tag/index/wdata.
//  - Both requests in the same cycle: port given by prio wins. A single requester always wins.
//  - ISSUE (1 cycle): gnt_x=1, l2_valid=1, l2_sel/rd/wr driven from latches. Go to WAIT.
//  - WAIT: l2_valid held and command stable; counter increments each cycle.
//    - l2_ack=1: go to DONE.
//    - else counter==timeout_cycs: go to DONE with abort flag.
//    - ack and timeout in the same cycle: ack wins, no error.
//  - l2_ack outside WAIT is ignored.
//  - DONE (1 cycle): l2_valid=0, done_x=1, timeout_err=abort flag.
//    prio flips to the other port, counter clears, go to IDLE.
//  - Grant latency: req sampled in cycle N -> gnt in N+1 -> earliest done in N+3 (ack in N+2).
//  - Min spacing between grants is 4 cycles. The loser keeps req high and is granted next IDLE.
//  - req_x dropped before done_x: the command still completes; done_x pulses anyway.
//  - Reset mid-operation: abort immediately to IDLE. No done/timeout pulse, latches cleared.
//  - The counter saturates at timeout_cycs and never wraps.
// TESTING
//  1 Reset: RST=0 two cycles -> all outputs 0. First tie after reset grants port 1.
//  2 req_1 rd tag=0xABCDEF idx=5, ack 2 cycles after gnt -> gnt_1@N+1, l2_rd=1, l2_tag=0xABCDEF, done_1@N+4.
//  3 req_1 and req_2 together, ack after 1 WAIT cycle each -> port1 served, then port2. Next tie goes to port 1.
//  4 req_2 wr, no ack -> l2_valid held 16 cycles, then done_2=1 with timeout_err=1, then back to IDLE.
//  5 ack in the same cycle as counter==15 -> done with timeout_err=0.
//  6 RST=0 during WAIT -> next cycle IDLE, l2_valid=0, no done. req_2 re-granted after reset release.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin arbiter/sequencer
// between two L1-side ports and the shared L2.
module l2_port_arbiter #(
  parameter int tag_bits     = 24,
  parameter int index_bits   = 7,
  parameter int block_size   = 512,
  parameter int timeout_cycs = 15,
  parameter int to_bits      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_1,
  input  logic                  req_2,
  input  logic                  wr_1,
  input  logic                  wr_2,
  input  logic [tag_bits-1:0]   tag_1,
  input  logic [tag_bits-1:0]   tag_2,
  input  logic [index_bits-1:0] index_1,
  input  logic [index_bits-1:0] index_2,
  input  logic [block_size-1:0] wdata_1,
  input  logic [block_size-1:0] wdata_2,
  output logic                  gnt_1,
  output logic                  gnt_2,
  output logic                  done_1,
  output logic                  done_2,
  output logic                  timeout_err,
  output logic                  l2_valid,
  output logic                  l2_sel,
  output logic                  l2_rd,
  output logic                  l2_wr,
  output logic [tag_bits-1:0]   l2_tag,
  output logic [index_bits-1:0] l2_index,
  output logic [block_size-1:0] l2_wdata,
  input  logic                  l2_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [to_bits-1:0] TO_LIM =
    to_bits'(timeout_cycs);

  state_t                state_q;
  logic                  prio_q;
  logic [to_bits-1:0]    cnt_q;
  logic                  gnt_1_q;
  logic                  gnt_2_q;
  logic                  done_1_q;
  logic                  done_2_q;
  logic                  terr_q;
  logic                  valid_q;
  logic                  sel_q;
  logic                  rd_q;
  logic                  wr_q;
  logic [tag_bits-1:0]   tag_q;
  logic [index_bits-1:0] index_q;
  logic [block_size-1:0] wdata_q;

  logic                  pick_2_d;
  logic [to_bits-1:0]    cnt_d;

  // Winner select and saturating wait counter.
  always_comb begin
    pick_2_d = req_2 & (~req_1 | prio_q);
    cnt_d    = cnt_q;
    if (cnt_q != TO_LIM)
      cnt_d = cnt_q + 1'b1;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      prio_q   <= 1'b0;
      cnt_q    <= '0;
      gnt_1_q  <= 1'b0;
      gnt_2_q  <= 1'b0;
      done_1_q <= 1'b0;
      done_2_q <= 1'b0;
      terr_q   <= 1'b0;
      valid_q  <= 1'b0;
      sel_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      tag_q    <= '0;
      index_q  <= '0;
      wdata_q  <= '0;
    end else begin
      gnt_1_q  <= 1'b0;
      gnt_2_q  <= 1'b0;
      done_1_q <= 1'b0;
      done_2_q <= 1'b0;
      terr_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_1 | req_2) begin
            state_q <= S_ISSUE;
            sel_q   <= pick_2_d;
            gnt_1_q <= ~pick_2_d;
            gnt_2_q <= pick_2_d;
            valid_q <= 1'b1;
            if (pick_2_d) begin
              rd_q    <= ~wr_2;
              wr_q    <= wr_2;
              tag_q   <= tag_2;
              index_q <= index_2;
              wdata_q <= wdata_2;
            end else begin
              rd_q    <= ~wr_1;
              wr_q    <= wr_1;
              tag_q   <= tag_1;
              index_q <= index_1;
              wdata_q <= wdata_1;
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (l2_ack || cnt_d == TO_LIM) begin
            state_q  <= S_DONE;
            valid_q  <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            done_1_q <= ~sel_q;
            done_2_q <= sel_q;
            terr_q   <= ~l2_ack;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          prio_q  <= ~sel_q;
          cnt_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_1       = gnt_1_q;
  assign gnt_2       = gnt_2_q;
  assign done_1      = done_1_q;
  assign done_2      = done_2_q;
  assign timeout_err = terr_q;
  assign l2_valid    = valid_q;
  assign l2_sel      = sel_q;
  assign l2_rd       = rd_q;
  assign l2_wr       = wr_q;
  assign l2_tag      = tag_q;
  assign l2_index    = index_q;
  assign l2_wdata    = wdata_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed-vector bench
// for the L2 port arbiter.
module tb_l2_port_arbiter;

  logic         CLK = 1'b0;
  logic         RST;
  logic         req_1, req_2, wr_1, wr_2;
  logic [23:0]  tag_1, tag_2;
  logic [6:0]   index_1, index_2;
  logic [511:0] wdata_1, wdata_2;
  logic         gnt_1, gnt_2, done_1, done_2;
  logic         timeout_err, l2_valid, l2_sel;
  logic         l2_rd, l2_wr, l2_ack;
  logic [23:0]  l2_tag;
  logic [6:0]   l2_index;
  logic [511:0] l2_wdata;

  int n_chk  = 0;
  int n_pass = 0;
  int vcnt;

  l2_port_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req_1(req_1), .req_2(req_2),
    .wr_1(wr_1), .wr_2(wr_2),
    .tag_1(tag_1), .tag_2(tag_2),
    .index_1(index_1), .index_2(index_2),
    .wdata_1(wdata_1), .wdata_2(wdata_2),
    .gnt_1(gnt_1), .gnt_2(gnt_2),
    .done_1(done_1), .done_2(done_2),
    .timeout_err(timeout_err),
    .l2_valid(l2_valid), .l2_sel(l2_sel),
    .l2_rd(l2_rd), .l2_wr(l2_wr),
    .l2_tag(l2_tag), .l2_index(l2_index),
    .l2_wdata(l2_wdata), .l2_ack(l2_ack)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0;
    req_1 = 1'b1; req_2 = 1'b1;
    wr_1 = 1'b0;  wr_2 = 1'b1;
    tag_1 = 24'h111111; tag_2 = 24'h222222;
    index_1 = 7'd3; index_2 = 7'd9;
    wdata_1 = {16{32'h1111_0000}};
    wdata_2 = {16{32'hCAFE_F00D}};
    l2_ack = 1'b1;

    // reset, inputs active but ignored
    step(); step();
    chk("rst_gnt", {gnt_1, gnt_2}, 2'b00);
    chk("rst_done", {done_1, done_2}, 2'b00);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_valid", l2_valid, 1'b0);
    chk("rst_sel", l2_sel, 1'b0);
    chk("rst_rdwr", {l2_rd, l2_wr}, 2'b00);
    chk("rst_tag", l2_tag, 24'h0);
    chk("rst_idx", l2_index, 7'h0);
    chk("rst_wdata", l2_wdata, 512'h0);

    // tie after reset: port 1 first
    RST = 1'b1; l2_ack = 1'b0;
    step();
    chk("tie1_gnt", {gnt_1, gnt_2}, 2'b10);
    chk("tie1_valid", l2_valid, 1'b1);
    chk("tie1_sel", l2_sel, 1'b0);
    chk("tie1_rdwr", {l2_rd, l2_wr}, 2'b10);
    chk("tie1_tag", l2_tag, 24'h111111);
    step();
    chk("tie1_wait_gnt", {gnt_1, gnt_2}, 2'b00);
    l2_ack = 1'b1;
    step();
    chk("tie1_done", {done_1, done_2}, 2'b10);
    chk("tie1_terr", timeout_err, 1'b0);
    chk("tie1_valid0", l2_valid, 1'b0);
    req_1 = 1'b0; l2_ack = 1'b0;
    step();
    chk("idle_gnt", {gnt_1, gnt_2}, 2'b00);
    step();
    chk("tie2_gnt", {gnt_1, gnt_2}, 2'b01);
    chk("tie2_sel", l2_sel, 1'b1);
    chk("tie2_rdwr", {l2_rd, l2_wr}, 2'b01);
    chk("tie2_idx", l2_index, 7'd9);
    chk("tie2_wdata", l2_wdata,
        {16{32'hCAFE_F00D}});
    step();
    l2_ack = 1'b1;
    step();
    chk("tie2_done", {done_1, done_2}, 2'b01);
    req_2 = 1'b0; l2_ack = 1'b0;
    step();
    req_1 = 1'b1; req_2 = 1'b1;
    step();
    chk("tie3_gnt", {gnt_1, gnt_2}, 2'b10);
    step();
    l2_ack = 1'b1;
    step();
    chk("tie3_done", {done_1, done_2}, 2'b10);
    req_1 = 1'b0; req_2 = 1'b0;
    step();
    // ack while idle must be ignored
    step();
    chk("ack_idle_valid", l2_valid, 1'b0);
    chk("ack_idle_done", {done_1, done_2}, 2'b00);
    l2_ack = 1'b0;

    // single read, ack two cycles after gnt
    req_1 = 1'b1; wr_1 = 1'b0;
    tag_1 = 24'hABCDEF; index_1 = 7'd5;
    step();
    chk("rd_gnt", {gnt_1, gnt_2}, 2'b10);
    chk("rd_rdwr", {l2_rd, l2_wr}, 2'b10);
    chk("rd_tag", l2_tag, 24'hABCDEF);
    chk("rd_idx", l2_index, 7'd5);
    step(); step();
    chk("rd_nodone", {done_1, done_2}, 2'b00);
    chk("rd_hold", l2_valid, 1'b1);
    l2_ack = 1'b1;
    step();
    chk("rd_done", {done_1, done_2}, 2'b10);
    chk("rd_valid0", l2_valid, 1'b0);
    req_1 = 1'b0; l2_ack = 1'b0;
    step();

    // write on port 2, no ack: timeout
    req_2 = 1'b1; wr_2 = 1'b1;
    step();
    chk("to_gnt", {gnt_1, gnt_2}, 2'b01);
    chk("to_wr", {l2_rd, l2_wr}, 2'b01);
    vcnt = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done_1 || done_2) break;
      if (l2_valid) vcnt++;
    end
    chk("to_vcycles", vcnt, 16);
    chk("to_done", {done_1, done_2}, 2'b01);
    chk("to_terr", timeout_err, 1'b1);
    chk("to_valid0", l2_valid, 1'b0);
    req_2 = 1'b0;
    step();
    step();
    chk("to_idle", {gnt_1, gnt_2, l2_valid}, 3'b000);

    // ack on the timeout cycle wins
    req_1 = 1'b1;
    step();
    chk("race_gnt", {gnt_1, gnt_2}, 2'b10);
    for (int i = 0; i < 15; i++) step();
    chk("race_nodone", {done_1, done_2}, 2'b00);
    l2_ack = 1'b1;
    step();
    chk("race_done", {done_1, done_2}, 2'b10);
    chk("race_terr", timeout_err, 1'b0);
    req_1 = 1'b0; l2_ack = 1'b0;
    step();

    // reset mid-WAIT
    req_2 = 1'b1; tag_2 = 24'h5A5A5A;
    step();
    chk("rw_gnt", {gnt_1, gnt_2}, 2'b01);
    step(); step();
    RST = 1'b0;
    step();
    chk("rw_valid0", l2_valid, 1'b0);
    chk("rw_nodone", {done_1, done_2}, 2'b00);
    chk("rw_terr", timeout_err, 1'b0);
    chk("rw_tag0", l2_tag, 24'h0);
    RST = 1'b1;
    step();
    chk("rw_regnt", {gnt_1, gnt_2}, 2'b01);
    chk("rw_tag", l2_tag, 24'h5A5A5A);
    req_2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
